// File: rtl/reg_file_operand_stage.sv
// Operand-fetch stage: 1W/2R register file feeding a latched R2/R3 operand pair
// to the ALU over a valid/ready handshake, with write-through bypass on capture.
module reg_file_operand_stage #(
  parameter int word_size = 32,
  parameter int addr_size = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [addr_size-1:0] wr_addr,
  input  logic [word_size-1:0] wr_data,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [addr_size-1:0] rd_addr2,
  input  logic [addr_size-1:0] rd_addr3,
  output logic [word_size-1:0] R2,
  output logic [word_size-1:0] R3,
  output logic                 op_valid,
  input  logic                 op_ready
);

  localparam int num_regs = 1 << addr_size;

  logic [word_size-1:0] regs [num_regs];
  logic [word_size-1:0] fetch2;
  logic [word_size-1:0] fetch3;
  logic                 wr_live;
  logic                 capture;

  assign wr_live  = wr_en && (wr_addr != '0);
  assign rd_ready = !op_valid || op_ready;
  assign capture  = rd_valid && rd_ready;

  // Address 0 reads as zero; a same-cycle write to a source wins over the stored entry.
  always_comb begin
    fetch2 = '0;
    if (rd_addr2 != '0) begin
      if (wr_live && (wr_addr == rd_addr2)) fetch2 = wr_data;
      else                                  fetch2 = regs[rd_addr2];
    end
  end

  always_comb begin
    fetch3 = '0;
    if (rd_addr3 != '0) begin
      if (wr_live && (wr_addr == rd_addr3)) fetch3 = wr_data;
      else                                  fetch3 = regs[rd_addr3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_regs; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      R2       <= '0;
      R3       <= '0;
      op_valid <= 1'b0;
    end else if (capture) begin
      R2       <= fetch2;
      R3       <= fetch3;
      op_valid <= 1'b1;
    end else if (op_valid && op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: doc/reg_file_operand_stage.md
Name: reg_file_operand_stage

Overview:
- Operand-fetch stage that sits directly upstream of the bitwise ALU units (OR_n_bit and its siblings) and drives their R2/R3 operand inputs.
- Holds a 2^addr_size x word_size register file with one write port and two read ports.
- Latches the two read operands into an output register.
- Hands operands to the ALU with a valid/ready handshake; a stalled ALU backpressures issue.

Parameters:
- word_size, 32, width of each register and of R2/R3.
- addr_size, 5, register address width; register count = 2^addr_size.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe for the register file.
- wr_addr  input  addr_size  write address.
- wr_data  input  word_size  write data.
- rd_valid  input  1  issue request: read rd_addr2/rd_addr3 this cycle.
- rd_ready  output  1  stage can accept an issue this cycle.
- rd_addr2  input  addr_size  source address for R2.
- rd_addr3  input  addr_size  source address for R3.
- R2  output  word_size  latched operand A to the ALU.
- R3  output  word_size  latched operand B to the ALU.
- op_valid  output  1  R2/R3 hold a valid operand pair.
- op_ready  input  1  ALU consumes the operand pair this cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - When rst=1 at a rising edge, all register-file entries become 0.
  - R2=0, R3=0, op_valid=0.
  - wr_en and rd_valid are ignored in that cycle.
  - rd_ready is combinational and reads 1 immediately after reset.
- Register 0:
  - Reads of address 0 return 0.
  - Writes to address 0 are discarded.
- Write:
  - When wr_en=1 and wr_addr!=0, the entry updates at the edge.
  - Writes are accepted every cycle, independent of the handshake.
- rd_ready = !op_valid || op_ready (combinational; no rd_valid to rd_ready path).
- Capture:
  - Occurs when rd_valid && rd_ready at an edge.
  - R2 <= value(rd_addr2), R3 <= value(rd_addr3), op_valid <= 1.
  - Latency: operands are visible the cycle after issue.
- Write-through bypass:
  - On capture, if wr_en=1, wr_addr!=0 and wr_addr equals a read address, that operand takes wr_data, not the old entry.
  - Applies independently to each read port, and to both ports when both match.
- Consume: if op_valid && op_ready and there is no capture in the same cycle, op_valid <= 0.
  - R2 and R3 hold their last values; they are don't-care to the ALU.
- Simultaneous consume and capture (op_valid=1, op_ready=1, rd_valid=1): new pair loaded and op_valid stays 1. This gives back-to-back throughput of one pair per cycle.
- Stall: while op_valid=1 and op_ready=0:
  - R2, R3 and op_valid are held stable.
  - rd_ready=0, so issues are not accepted.
  - Later writes to the source registers do NOT modify the latched R2/R3. The operand pair is a snapshot taken at capture.
- rd_addr2 == rd_addr3 is legal; R2 and R3 both receive the same value.
- No X propagation: every output is defined from reset onward.

Test Plan:
- Reset, then write reg3=32'h0000_00F0 and reg7=32'h0000_000F. Issue rd_addr2=3, rd_addr3=7 with op_ready=1 -> next cycle R2=0000_00F0, R3=0000_000F, op_valid=1; downstream OR yields 0000_00FF.
- Write reg0=32'hDEAD_BEEF, then issue reading 0/0 -> R2=R3=0, op_valid=1.
- Bypass, reg5 initially 32'h1111_1111. Same cycle: wr_en=1, wr_addr=5, wr_data=32'hA5A5_A5A5, and issue rd_addr2=5, rd_addr3=2 -> R2=A5A5_A5A5, R3=reg2 value.
- Stall:
  - Capture a pair (reg4=32'h1234_5678 into R2), then hold op_ready=0 for 3 cycles while writing reg4=32'hFFFF_FFFF and asserting rd_valid -> rd_ready=0, R2 remains 1234_5678, op_valid=1.
  - Release op_ready -> the pending issue is captured that cycle and R2=FFFF_FFFF next cycle.
- Back-to-back: hold op_ready=1 and issue 4 consecutive pairs -> 4 consecutive op_valid cycles with the correct operands, no bubbles, rd_ready=1 throughout.
- Reset mid-operation: with op_valid=1 and stalled, assert rst for one cycle alongside wr_en=1 (reg9=32'h5555_5555) -> op_valid=0, R2=R3=0, and reading reg9 afterward returns 0.
